restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured on the accepting edge.
REQ-006 SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-009 SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-010 SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-011 SHALL have port div_by_zero, output, 1 bit: high when the last completed operation had divisor == 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE, encoded in 2 bits.
REQ-013 In IDLE with start = 1 and divisor != 0, the block SHALL, on that edge (E0), capture the operands, clear the partial remainder (WIDTH+1 bits), load the iteration counter with WIDTH, and enter RUN.
REQ-014 In IDLE with start = 1 and divisor == 0, the block SHALL, on E0, set quotient to all ones, set remainder to dividend and div_by_zero to 1, and enter DONE.
REQ-015 On the E0 of REQ-013, the block SHALL clear div_by_zero.
REQ-016 Each RUN edge SHALL perform one iteration:
  - shift the partial remainder left 1 bit;
  - shift in the MSB of the dividend shift register;
  - compute diff = shifted - {1'b0, divisor} with a (WIDTH+1)-bit subtractor that produces a borrow.
REQ-017 If borrow == 0, the block SHALL write diff to the partial remainder and shift a 1 into the quotient LSB; otherwise it SHALL keep the shifted value and shift in a 0.
REQ-018 Each RUN edge SHALL decrement the counter; the edge that moves it from 1 to 0 (edge E_WIDTH) SHALL complete the last iteration and enter DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return to IDLE.
REQ-020 done SHALL be visible WIDTH edges after E0 for the normal path, and immediately after E0 for divide-by-zero.
REQ-021 quotient and remainder SHALL update only on the completing edge and SHALL hold until the next completion or reset.
REQ-022 remainder SHALL equal the low WIDTH bits of the final partial remainder, which is always < divisor.
REQ-023 start SHALL be ignored in RUN and DONE, with no queuing; operand changes after E0 SHALL NOT affect the result.
REQ-024 start held high continuously SHALL launch a new operation on the edge after DONE (back-to-back throughput of WIDTH+2 cycles).
REQ-025 busy SHALL be 0 in IDLE and DONE, and done SHALL be 0 outside DONE.

Reset
REQ-026 rst = 1 on an edge SHALL force IDLE and clear busy, done, quotient, remainder, div_by_zero and all internal registers, regardless of state.
REQ-027 rst SHALL take priority over start; an operation interrupted by reset SHALL NOT assert done.
REQ-028 The first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH = 4)
REQ-029 Apply start with 13 / 3 -> busy for 4 cycles, then done pulse with quotient = 4, remainder = 1, div_by_zero = 0.
REQ-030 Apply start with 7 / 0 -> done in the cycle after E0, with quotient = 15, remainder = 7, div_by_zero = 1, and busy never asserted.
REQ-031 Run two divisions back to back:
  - 15 / 1 -> quotient = 15, remainder = 0;
  - 2 / 5 -> quotient = 0, remainder = 2.
REQ-032 Start 9 / 2, then pulse start with 1 / 1 in the second RUN cycle -> the second request is ignored, the result is quotient = 4, remainder = 1, and exactly one done pulse occurs.
REQ-033 Start 14 / 3 and assert rst on the second RUN edge -> state is IDLE, all outputs are 0, and no done pulse occurs; a subsequent start with 14 / 3 gives quotient = 4, remainder = 2.
REQ-034 Run an exhaustive sweep of all 256 operand pairs -> results match integer / and %, with the divide-by-zero rules of REQ-014.

Source files
------------

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// Produces one quotient bit per clock in RUN; divide-by-zero short-circuits
// straight to DONE with quotient = all ones and remainder = dividend.
module restoring_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // Counter must hold the value WIDTH itself.
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shift register, MSB consumed first
    logic [WIDTH-1:0] dvs_q, dvs_d;   // captured divisor
    logic [WIDTH:0]   prem_q, prem_d; // partial remainder, one guard bit
    logic [WIDTH-1:0] qsr_q, qsr_d;   // quotient bits accumulated so far
    logic [CntW-1:0]  cnt_q, cnt_d;   // iterations left
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] sub_full;
    logic             borrow;
    logic [WIDTH:0]   prem_next;
    logic             q_bit;
    logic [WIDTH-1:0] qsr_next;

    // One restoring step: shift, trial-subtract, keep difference if no borrow.
    always_comb begin
        shifted   = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        sub_full  = {1'b0, shifted} - {2'b00, dvs_q};
        borrow    = sub_full[WIDTH+1];
        q_bit     = ~borrow;
        prem_next = borrow ? shifted : sub_full[WIDTH:0];
        qsr_next  = {qsr_q[WIDTH-2:0], q_bit};
    end

    // Next-state and datapath update decisions.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qsr_d   = qsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor != '0) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        prem_d  = '0;
                        qsr_d   = '0;
                        cnt_d   = CntW'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = StRun;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                prem_d = prem_next;
                qsr_d  = qsr_next;
                dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - CntW'(1);
                // Last iteration: publish results on this same edge.
                if (cnt_q == CntW'(1)) begin
                    quot_d  = qsr_next;
                    rem_d   = prem_next[WIDTH-1:0];
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            qsr_q  <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            prem_q <= prem_d;
            qsr_q  <= qsr_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    // Status and result outputs.
    always_comb begin
        busy        = (state_q == StRun);
        done        = (state_q == StDone);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider at WIDTH = 4.
module tb_restoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    restoring_divider #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Count done pulses (one count per cycle spent in DONE).
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one division and wait for done; lat = edges from E0 (inclusive) to done.
    task automatic do_div(input logic [3:0] a, input logic [3:0] b,
                          output int lat, output int busy_cnt);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        lat      = 0;
        busy_cnt = 0;
        while (lat < 50) begin
            tick();
            lat++;
            start = 1'b0;
            if (done) break;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd3;
        tick();
        tick();
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 0", {busy, done, quotient, remainder,
                     div_by_zero});
        end
        start = 1'b0;
        rst   = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        do_div(4'd13, 4'd3, lat, bc);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d expected 5", lat);
        end
        vectors++;
        if (bc !== 4) begin
            miscompares++;
            $display("FAIL basic_busy_cycles: got %0d expected 4", bc);
        end
        vectors++;
        if ({quotient, remainder, div_by_zero} !== {4'd4, 4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_13_3: got q=%0d r=%0d z=%b expected q=4 r=1 z=0",
                     quotient, remainder, div_by_zero);
        end
        tick();
        tick();
        tick();
        vectors++;
        if ({done, busy, quotient, remainder} !== {1'b0, 1'b0, 4'd4, 4'd1}) begin
            miscompares++;
            $display("FAIL basic_hold: got done=%b busy=%b q=%0d r=%0d expected 0 0 4 1",
                     done, busy, quotient, remainder);
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        do_div(4'd7, 4'd0, lat, bc);
        vectors++;
        if (lat !== 1 || bc !== 0) begin
            miscompares++;
            $display("FAIL dbz_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, bc);
        end
        vectors++;
        if ({quotient, remainder, div_by_zero} !== {4'd15, 4'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL dbz_7_0: got q=%0d r=%0d z=%b expected q=15 r=7 z=1",
                     quotient, remainder, div_by_zero);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd1;
        tick();
        // Next operands presented while the first runs; start stays high.
        dividend = 4'd2;
        divisor  = 4'd5;
        lat = 1;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 5 || {quotient, remainder} !== {4'd15, 4'd0}) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected lat=5 q=15 r=0",
                     lat, quotient, remainder);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_gap: got busy=%b done=%b expected 0 0", busy, done);
        end
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_relaunch: got busy=%b expected 1", busy);
        end
        start = 1'b0;
        lat = 1;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 5 || {quotient, remainder, div_by_zero} !== {4'd0, 4'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d z=%b expected lat=5 q=0 r=2 z=0",
                     lat, quotient, remainder, div_by_zero);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int lat, d0;
        d0       = done_cnt;
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        tick();
        start = 1'b0;
        tick();
        // Second RUN cycle: stray request with new operands.
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 50) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 5 || {quotient, remainder} !== {4'd4, 4'd1}) begin
            miscompares++;
            $display("FAIL ignore_result: got lat=%0d q=%0d r=%0d expected lat=5 q=4 r=1",
                     lat, quotient, remainder);
        end
        tick();
        tick();
        tick();
        vectors++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignore_single_done: got pulses=%0d busy=%b expected 1 0",
                     done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, d0;
        d0       = done_cnt;
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %b expected 0", {busy, done, quotient,
                     remainder, div_by_zero});
        end
        repeat (6) tick();
        vectors++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_no_done: got pulses=%0d busy=%b expected 0 0",
                     done_cnt - d0, busy);
        end
        do_div(4'd14, 4'd3, lat, bc);
        vectors++;
        if (lat !== 5 || {quotient, remainder, div_by_zero} !== {4'd4, 4'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset_restart: got lat=%0d q=%0d r=%0d z=%b expected 5 4 2 0",
                     lat, quotient, remainder, div_by_zero);
        end
        tick();
    endtask

    task automatic test_sweep();
        int lat, bc, exp_lat;
        logic [3:0] eq, er;
        logic       ez;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_div(4'(a), 4'(b), lat, bc);
                if (b == 0) begin
                    eq = 4'd15;
                    er = 4'(a);
                    ez = 1'b1;
                    exp_lat = 1;
                end else begin
                    eq = 4'(a / b);
                    er = 4'(a % b);
                    ez = 1'b0;
                    exp_lat = 5;
                end
                vectors++;
                if ({quotient, remainder, div_by_zero} !== {eq, er, ez} || lat !== exp_lat) begin
                    miscompares++;
                    $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b lat=%0d",
                             a, b, quotient, remainder, div_by_zero, lat, eq, er, ez, exp_lat);
                end
                tick();
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
